// File: rtl/mac_scheduler_if.sv
// Bundle between mac_scheduler and its environment: sample strobe, coefficient
// table, combinational MAC datapath operands/result and filter status.
interface mac_scheduler_if #(
  parameter int N  = 25,
  parameter int AW = 2
);
  logic                 start;
  logic [N-1:0]         x_in;
  logic [AW-1:0]        coef_addr;
  logic [N-1:0]         coef_data;
  logic [N-1:0]         constantes_o;
  logic [N-1:0]         multip_o;
  // Datapath adds entrada_o sign-extended and aligned to the product's binary point.
  logic [N-1:0]         entrada_o;
  logic [2*N-1:0]       valores_i;
  logic [N-1:0]         y_out;
  logic                 done;
  logic                 busy;
  logic                 sat;
  logic                 overrun;

  modport master (
    input  start, x_in, coef_data, valores_i,
    output coef_addr, constantes_o, multip_o, entrada_o,
    output y_out, done, busy, sat, overrun
  );

  modport slave (
    output start, x_in, coef_data, valores_i,
    input  coef_addr, constantes_o, multip_o, entrada_o,
    input  y_out, done, busy, sat, overrun
  );
endinterface

// File: rtl/mac_scheduler.sv
// TAPS-tap fixed-point filter sequencer: runs one pass over the shared MAC
// datapath per sample strobe, saturating the accumulator back to N bits per tap.
module mac_scheduler #(
  parameter int N    = 25,
  parameter int F    = 12,
  parameter int TAPS = 3
) (
  input logic             clk,
  input logic             reset,
  mac_scheduler_if.master bus
);
  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [N-1:0]  h_r [TAPS];
  logic [N-1:0]  x_hold_r;
  logic [N-1:0]  acc_r;
  logic [AW-1:0] idx_r;
  logic [N-1:0]  y_r;
  logic          done_r;
  logic          sat_r;
  logic          overrun_r;

  function automatic logic sum_overflows(input logic [2*N-1:0] v);
    logic [N-F:0] top;
    top = v[2*N-1:F+N-1];
    return !((&top) || (~|top));
  endfunction

  // Floor to the N-bit window at the binary point, clamping on overflow.
  function automatic logic [N-1:0] trunc_sat(input logic [2*N-1:0] v);
    if (!sum_overflows(v)) begin
      return v[F+N-1:F];
    end else if (v[2*N-1] == 1'b0) begin
      return {1'b0, {(N-1){1'b1}}};
    end else begin
      return {1'b1, {(N-1){1'b0}}};
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = MAC;
      MAC: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = MAC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Delay line, accumulator, tap index and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        h_r[k] <= {N{1'b0}};
      end
      x_hold_r  <= {N{1'b0}};
      acc_r     <= {N{1'b0}};
      idx_r     <= {AW{1'b0}};
      y_r       <= {N{1'b0}};
      done_r    <= 1'b0;
      sat_r     <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // A strobe outside IDLE never touches the holding register.
      if (bus.start && (state_r == IDLE)) begin
        x_hold_r <= bus.x_in;
      end else if (bus.start) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        LOAD: begin
          h_r[0] <= x_hold_r;
          for (int k = 1; k < TAPS; k++) begin
            h_r[k] <= h_r[k-1];
          end
          acc_r <= {N{1'b0}};
          idx_r <= {AW{1'b0}};
        end
        MAC: begin
          acc_r <= trunc_sat(bus.valores_i);
          idx_r <= idx_r + {{(AW-1){1'b0}}, 1'b1};
          sat_r <= sat_r | sum_overflows(bus.valores_i);
        end
        DONE: begin
          y_r    <= acc_r;
          done_r <= 1'b1;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Datapath operands, only live during MAC.
  always_comb begin
    bus.coef_addr    = {AW{1'b0}};
    bus.constantes_o = {N{1'b0}};
    bus.multip_o     = {N{1'b0}};
    bus.entrada_o    = {N{1'b0}};
    if (state_r == MAC) begin
      bus.coef_addr    = idx_r;
      bus.constantes_o = bus.coef_data;
      bus.multip_o     = h_r[idx_r];
      bus.entrada_o    = acc_r;
    end else begin
      bus.coef_addr    = {AW{1'b0}};
      bus.constantes_o = {N{1'b0}};
      bus.multip_o     = {N{1'b0}};
      bus.entrada_o    = {N{1'b0}};
    end
  end

  assign bus.y_out   = y_r;
  assign bus.done    = done_r;
  assign bus.busy    = (state_r != IDLE);
  assign bus.sat     = sat_r;
  assign bus.overrun = overrun_r;
endmodule
